conv3x3_window_reader: RTL

//  Downstream consumer of the 64x8 pixel RAM. On start, walks every valid 3x3

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv3x3_mac.sv | 27 ++
 rtl/conv3x3_window_reader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and tap address helper for the 3x3 window reader.
package conv_pkg;
    localparam int IMG_W    = 8;
    localparam int IMG_H    = 8;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int W_W      = 8;
    localparam int NTAPS    = 9;
    localparam int POS_W    = 3;
    localparam int TAP_W    = 4;
    // 17-bit products summed nine times need four growth bits: 8+8+4 = 20.
    localparam int ACC_W    = DATA_W + W_W + $clog2(NTAPS);
    localparam int LAST_ROW = IMG_H - 3;
    localparam int LAST_COL = IMG_W - 3;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, DONE} state_t;

    function automatic logic [ADDR_W-1:0] tap_addr(input logic [POS_W-1:0] row,
                                                   input logic [POS_W-1:0] col,
                                                   input logic [TAP_W-1:0] tap);
        int ky;
        int kx;
        ky = int'(tap) / 3;
        kx = int'(tap) % 3;
        return ADDR_W'((int'(row) + ky) * IMG_W + int'(col) + kx);
    endfunction
endpackage

// File: rtl/conv3x3_mac.sv
// Unsigned pixel x signed coefficient multiply-accumulate; result updates 1 cycle after en.
// No backpressure: clr/en are fully controlled by the caller.
module conv3x3_mac
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic [DATA_W-1:0]       i_pix,
    input  logic [W_W-1:0]          i_coef,
    output logic signed [ACC_W-1:0] o_acc
);
    logic signed [DATA_W+W_W:0] w_prod;

    assign w_prod = $signed({1'b0, i_pix}) * $signed(i_coef);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_acc <= '0;
        end else if (i_clr) begin
            o_acc <= '0;
        end else if (i_en) begin
            o_acc <= o_acc + ACC_W'(w_prod);
        end
    end
endmodule

// File: rtl/conv3x3_window_reader.sv
// Walks all 3x3 windows of the pixel RAM, 11 cycles/window, first result 11 cycles after start.
// Holds each result (and the RAM address) while out_ready is low; start is ignored while busy.
module conv3x3_window_reader
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NTAPS*W_W-1:0]    kernel,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_wr,
    input  logic [DATA_W-1:0]       ram_dout,
    output logic signed [ACC_W-1:0] out_data,
    output logic [POS_W-1:0]        out_row,
    output logic [POS_W-1:0]        out_col,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);
    state_t                        r_state;
    logic [NTAPS-1:0][W_W-1:0]     r_kernel;
    logic [POS_W-1:0]              r_row;
    logic [POS_W-1:0]              r_col;
    logic [TAP_W-1:0]              r_tap;
    logic [ADDR_W-1:0]             r_addr;
    logic                          r_valid;
    logic                          r_busy;
    logic                          r_done;

    logic                          w_last_col;
    logic                          w_last_win;
    logic [POS_W-1:0]              w_nxt_row;
    logic [POS_W-1:0]              w_nxt_col;
    logic                          w_clr;
    logic                          w_en;
    logic [TAP_W-1:0]              w_kidx;
    logic [W_W-1:0]                w_coef;
    logic signed [ACC_W-1:0]       w_acc;

    // RAM data lags the address by one cycle, so tap t's pixel meets k[t-1].
    always_comb begin
        w_last_col = (r_col == POS_W'(LAST_COL));
        w_last_win = w_last_col && (r_row == POS_W'(LAST_ROW));
        w_nxt_col  = w_last_col ? '0 : r_col + 1'b1;
        w_nxt_row  = w_last_col ? r_row + 1'b1 : r_row;
        w_clr      = (r_state == READ) && (r_tap == '0);
        w_en       = ((r_state == READ) && (r_tap != '0)) || (r_state == DRAIN);
        w_kidx     = ((r_state == READ) && (r_tap != '0)) ? r_tap - 1'b1 : TAP_W'(NTAPS - 1);
        w_coef     = r_kernel[w_kidx];
    end

    conv3x3_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_pix  (ram_dout),
        .i_coef (w_coef),
        .o_acc  (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_kernel <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_tap    <= '0;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= READ;
                        r_kernel <= kernel;
                        r_busy   <= 1'b1;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_tap    <= '0;
                        r_addr   <= tap_addr('0, '0, '0);
                    end
                end
                READ: begin
                    if (r_tap == TAP_W'(NTAPS - 1)) begin
                        r_state <= DRAIN;
                    end else begin
                        r_tap  <= r_tap + 1'b1;
                        r_addr <= tap_addr(r_row, r_col, r_tap + 1'b1);
                    end
                end
                DRAIN: begin
                    r_state <= OUT;
                    r_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (w_last_win) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= READ;
                            r_row   <= w_nxt_row;
                            r_col   <= w_nxt_col;
                            r_tap   <= '0;
                            r_addr  <= tap_addr(w_nxt_row, w_nxt_col, '0);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_addr  = r_addr;
    assign ram_wr    = 1'b0;
    assign out_data  = w_acc;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule
